// File: rtl/cache_ahb_burst_ctrl_if.sv
// AHB master-side signal bundle for the cache burst controller.
// The master modport drives the address/data phase; the slave modport returns HRDATA/HREADY.
interface cache_ahb_burst_ctrl_if #(
    parameter int PA_BITS = 34,
    parameter int AHBW    = 64
);
    logic [PA_BITS-1:0] HADDR;
    logic [1:0]         HTRANS;
    logic               HWRITE;
    logic [2:0]         HBURST;
    logic [2:0]         HSIZE;
    logic [AHBW-1:0]    HWDATA;
    logic [AHBW-1:0]    HRDATA;
    logic               HREADY;

    modport master (
        output HADDR, HTRANS, HWRITE, HBURST, HSIZE, HWDATA,
        input  HRDATA, HREADY
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HBURST, HSIZE, HWDATA,
        output HRDATA, HREADY
    );
endinterface

// File: rtl/cache_ahb_burst_ctrl.sv
// Cache-line burst controller: one fixed-length incrementing AHB burst per fetch/writeback.
// Handshake: a transfer beat completes on any cycle where HREADY is high; CacheBusAck pulses with the last one.
module cache_ahb_burst_ctrl #(
    parameter int PA_BITS      = 34,
    parameter int AHBW         = 64,
    parameter int LINELEN      = 512,
    parameter int BEATSPERLINE = LINELEN / AHBW,
    parameter int LOGBWPL      = $clog2(BEATSPERLINE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Stall,
    input  logic                 Flush,
    input  logic [1:0]           CacheBusRW,
    input  logic [PA_BITS-1:0]   CacheBusAdr,
    input  logic [AHBW-1:0]      CacheReadDataWord,
    output logic                 CacheBusAck,
    output logic                 SelBusBeat,
    output logic [LOGBWPL-1:0]   BeatCount,
    output logic [LINELEN-1:0]   FetchBuffer,
    output logic                 BusCommitted,
    output logic [1:0]           DebugState,
    cache_ahb_burst_ctrl_if.master ahb
);
    localparam int OFFSET = $clog2(LINELEN / 8);
    localparam logic [LOGBWPL-1:0] LAST_BEAT = LOGBWPL'(BEATSPERLINE - 1);
    localparam logic [2:0] BURST_TYPE = (BEATSPERLINE == 4)  ? 3'b011 :
                                        (BEATSPERLINE == 8)  ? 3'b101 :
                                        (BEATSPERLINE == 16) ? 3'b111 : 3'b001;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH     = 2'd1,
        WRITEBACK = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t               state, nextState;
    logic [1:0]           htrans;
    logic [LOGBWPL-1:0]   adrBeat;
    logic                 inBurst;
    logic                 unusedAdrBits;

    assign inBurst = (state == FETCH) || (state == WRITEBACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            BeatCount   <= '0;
            FetchBuffer <= '0;
        end else begin
            state <= nextState;
            // Last beat wraps BeatCount back to zero since BEATSPERLINE is a power of two.
            if (inBurst && ahb.HREADY) begin
                BeatCount <= BeatCount + LOGBWPL'(1);
                if (state == FETCH) begin
                    for (int k = 0; k < BEATSPERLINE; k++) begin
                        if (BeatCount == LOGBWPL'(k))
                            FetchBuffer[k*AHBW +: AHBW] <= ahb.HRDATA;
                    end
                end
            end
        end
    end

    always_comb begin
        nextState   = state;
        htrans      = 2'b00;
        CacheBusAck = 1'b0;
        case (state)
            IDLE: begin
                if ((CacheBusRW != 2'b00) && !Flush) begin
                    htrans = 2'b10;
                    if (ahb.HREADY)
                        nextState = CacheBusRW[1] ? FETCH : WRITEBACK;
                end
            end
            FETCH, WRITEBACK: begin
                htrans = (BeatCount < LAST_BEAT) ? 2'b11 : 2'b00;
                if (ahb.HREADY && (BeatCount == LAST_BEAT)) begin
                    CacheBusAck = 1'b1;
                    nextState   = DONE;
                end
            end
            DONE: begin
                if (!Stall)
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Address phase runs one beat ahead of the data phase tracked by BeatCount.
    assign adrBeat = (state == IDLE) ? '0 : BeatCount + LOGBWPL'(1);

    assign ahb.HADDR  = {CacheBusAdr[PA_BITS-1:OFFSET], adrBeat, {(OFFSET-LOGBWPL){1'b0}}};
    assign ahb.HTRANS = htrans;
    assign ahb.HWRITE = (state == IDLE) ? CacheBusRW[0] : (state == WRITEBACK);
    assign ahb.HBURST = BURST_TYPE;
    assign ahb.HSIZE  = 3'($clog2(AHBW / 8));
    assign ahb.HWDATA = (state == WRITEBACK) ? CacheReadDataWord : '0;

    assign SelBusBeat   = (state == WRITEBACK) || ((state == IDLE) && CacheBusRW[0]);
    assign BusCommitted = inBurst;
    assign DebugState   = state;

    assign unusedAdrBits = &{1'b0, CacheBusAdr[OFFSET-1:0]};
endmodule

// File: tb/tb_cache_ahb_burst_ctrl.sv
// Directed bench for cache_ahb_burst_ctrl: fetch, writeback with wait states, flush, stall, reset abort, 4-beat line.
module tb_cache_ahb_burst_ctrl;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WB = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [33:0] BASE = 34'h080001040;

    logic clk;
    logic reset;

    // 8-beat instance
    logic         stall, flush;
    logic [1:0]   rw;
    logic [33:0]  adr;
    logic [63:0]  rdWord;
    logic         ack, selBeat, committed;
    logic [2:0]   beatCount;
    logic [511:0] fetchBuf;
    logic [1:0]   dbgState;

    // 4-beat instance
    logic         stall4, flush4;
    logic [1:0]   rw4;
    logic [33:0]  adr4;
    logic [63:0]  rdWord4;
    logic         ack4, selBeat4, committed4;
    logic [1:0]   beatCount4;
    logic [255:0] fetchBuf4;
    logic [1:0]   dbgState4;

    cache_ahb_burst_ctrl_if #(.PA_BITS(34), .AHBW(64)) ahb8 ();
    cache_ahb_burst_ctrl_if #(.PA_BITS(34), .AHBW(64)) ahb4 ();

    cache_ahb_burst_ctrl #(.PA_BITS(34), .AHBW(64), .LINELEN(512)) u8 (
        .clk(clk), .reset(reset), .Stall(stall), .Flush(flush),
        .CacheBusRW(rw), .CacheBusAdr(adr), .CacheReadDataWord(rdWord),
        .CacheBusAck(ack), .SelBusBeat(selBeat), .BeatCount(beatCount),
        .FetchBuffer(fetchBuf), .BusCommitted(committed), .DebugState(dbgState),
        .ahb(ahb8)
    );

    cache_ahb_burst_ctrl #(.PA_BITS(34), .AHBW(64), .LINELEN(256)) u4 (
        .clk(clk), .reset(reset), .Stall(stall4), .Flush(flush4),
        .CacheBusRW(rw4), .CacheBusAdr(adr4), .CacheReadDataWord(rdWord4),
        .CacheBusAck(ack4), .SelBusBeat(selBeat4), .BeatCount(beatCount4),
        .FetchBuffer(fetchBuf4), .BusCommitted(committed4), .DebugState(dbgState4),
        .ahb(ahb4)
    );

    int total = 0;
    int bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    logic [511:0] expFb;
    logic [255:0] expFb4;
    int           wbBeat [10];
    bit           wbRdy  [10];

    initial begin
        wbBeat = '{0, 1, 2, 3, 3, 3, 4, 5, 6, 7};
        wbRdy  = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};

        reset = 1'b1;
        stall = 0; flush = 0; rw = 2'b00; adr = '0; rdWord = '0;
        stall4 = 0; flush4 = 0; rw4 = 2'b00; adr4 = '0; rdWord4 = '0;
        ahb8.HRDATA = '0; ahb8.HREADY = 1'b0;
        ahb4.HRDATA = '0; ahb4.HREADY = 1'b0;
        tick();
        tick();

        // Reset state
        #2;
        chk("rst_state", 512'(dbgState), 512'(S_IDLE));
        chk("rst_htrans", 512'(ahb8.HTRANS), 512'(2'b00));
        chk("rst_ack", 512'(ack), 512'(1'b0));
        chk("rst_sel", 512'(selBeat), 512'(1'b0));
        chk("rst_committed", 512'(committed), 512'(1'b0));
        chk("rst_hwrite", 512'(ahb8.HWRITE), 512'(1'b0));
        chk("rst_haddr", 512'(ahb8.HADDR), 512'(34'h0));
        chk("rst_hwdata", 512'(ahb8.HWDATA), 512'(64'h0));
        chk("rst_beat", 512'(beatCount), 512'(3'd0));
        chk("rst_fetchbuf", fetchBuf, 512'(0));
        chk("hburst8", 512'(ahb8.HBURST), 512'(3'b101));
        chk("hsize", 512'(ahb8.HSIZE), 512'(3'b011));
        reset = 1'b0;

        // Fetch, HREADY always high, HRDATA = beat index
        rw = 2'b10; adr = BASE; ahb8.HREADY = 1'b1;
        #2;
        chk("f_nonseq", 512'(ahb8.HTRANS), 512'(2'b10));
        chk("f_haddr0", 512'(ahb8.HADDR), 512'(BASE));
        chk("f_hwrite", 512'(ahb8.HWRITE), 512'(1'b0));
        chk("f_sel", 512'(selBeat), 512'(1'b0));
        tick();
        expFb = '0;
        for (int k = 0; k < 8; k++) begin
            ahb8.HRDATA = 64'(k);
            expFb[k*64 +: 64] = 64'(k);
            #2;
            chk("f_state", 512'(dbgState), 512'(S_FETCH));
            chk("f_beat", 512'(beatCount), 512'(k));
            chk("f_htrans", 512'(ahb8.HTRANS), 512'((k < 7) ? 2'b11 : 2'b00));
            chk("f_ack", 512'(ack), 512'(k == 7));
            chk("f_committed", 512'(committed), 512'(1'b1));
            if (k < 7) chk("f_haddr", 512'(ahb8.HADDR), 512'(BASE + 34'(8 * (k + 1))));
            tick();
        end
        rw = 2'b00;
        #2;
        chk("f_done_state", 512'(dbgState), 512'(S_DONE));
        chk("f_done_ack", 512'(ack), 512'(1'b0));
        chk("f_done_htrans", 512'(ahb8.HTRANS), 512'(2'b00));
        chk("f_done_committed", 512'(committed), 512'(1'b0));
        chk("f_fetchbuf", fetchBuf, expFb);
        tick();
        #2;
        chk("f_idle_state", 512'(dbgState), 512'(S_IDLE));

        // Writeback with two wait states at beat 3
        rw = 2'b01; rdWord = 64'hC0DE_0000_0000_0000;
        #2;
        chk("w_nonseq", 512'(ahb8.HTRANS), 512'(2'b10));
        chk("w_hwrite0", 512'(ahb8.HWRITE), 512'(1'b1));
        chk("w_sel0", 512'(selBeat), 512'(1'b1));
        chk("w_haddr0", 512'(ahb8.HADDR), 512'(BASE));
        tick();
        for (int c = 0; c < 10; c++) begin
            ahb8.HREADY = wbRdy[c];
            rdWord = 64'hC0DE_0000_0000_0000 | 64'(wbBeat[c]);
            #2;
            chk("w_state", 512'(dbgState), 512'(S_WB));
            chk("w_beat", 512'(beatCount), 512'(wbBeat[c]));
            chk("w_hwdata", 512'(ahb8.HWDATA), 512'(64'hC0DE_0000_0000_0000 | 64'(wbBeat[c])));
            chk("w_htrans", 512'(ahb8.HTRANS), 512'((wbBeat[c] < 7) ? 2'b11 : 2'b00));
            chk("w_ack", 512'(ack), 512'(c == 9));
            chk("w_hwrite", 512'(ahb8.HWRITE), 512'(1'b1));
            chk("w_sel", 512'(selBeat), 512'(1'b1));
            if (wbBeat[c] < 7) chk("w_haddr", 512'(ahb8.HADDR), 512'(BASE + 34'(8 * (wbBeat[c] + 1))));
            tick();
        end
        rw = 2'b00; ahb8.HREADY = 1'b1;
        #2;
        chk("w_done_state", 512'(dbgState), 512'(S_DONE));
        chk("w_fetchbuf_held", fetchBuf, expFb);
        tick();

        // Flush blocks acceptance, then burst starts once it drops
        rw = 2'b10; flush = 1'b1; ahb8.HRDATA = '0;
        for (int d = 0; d < 3; d++) begin
            #2;
            chk("fl_htrans", 512'(ahb8.HTRANS), 512'(2'b00));
            chk("fl_ack", 512'(ack), 512'(1'b0));
            chk("fl_state", 512'(dbgState), 512'(S_IDLE));
            tick();
        end
        flush = 1'b0;
        #2;
        chk("fl_nonseq", 512'(ahb8.HTRANS), 512'(2'b10));
        tick();

        // Stall across the ack cycle and three more; pending request waits for IDLE
        expFb = '0;
        for (int k = 0; k < 8; k++) begin
            ahb8.HRDATA = 64'h100 + 64'(k);
            expFb[k*64 +: 64] = 64'h100 + 64'(k);
            stall = (k == 7);
            #2;
            chk("st_ack", 512'(ack), 512'(k == 7));
            tick();
        end
        for (int d = 0; d < 4; d++) begin
            stall = (d < 3);
            #2;
            chk("st_done_state", 512'(dbgState), 512'(S_DONE));
            chk("st_done_htrans", 512'(ahb8.HTRANS), 512'(2'b00));
            chk("st_done_ack", 512'(ack), 512'(1'b0));
            tick();
        end
        #2;
        chk("st_idle_state", 512'(dbgState), 512'(S_IDLE));
        chk("st_pending_nonseq", 512'(ahb8.HTRANS), 512'(2'b10));
        chk("st_fetchbuf", fetchBuf, expFb);
        tick();

        // Reset at beat 4 of a fetch aborts the burst
        for (int k = 0; k < 4; k++) begin
            ahb8.HRDATA = 64'h200 + 64'(k);
            #2;
            chk("ra_beat", 512'(beatCount), 512'(k));
            tick();
        end
        reset = 1'b1; rw = 2'b00;
        tick();
        reset = 1'b0;
        #2;
        chk("ra_htrans", 512'(ahb8.HTRANS), 512'(2'b00));
        chk("ra_beat0", 512'(beatCount), 512'(3'd0));
        chk("ra_fetchbuf", fetchBuf, 512'(0));
        chk("ra_committed", 512'(committed), 512'(1'b0));
        chk("ra_state", 512'(dbgState), 512'(S_IDLE));
        tick();
        rw = 2'b10;
        #2;
        chk("ra_nonseq", 512'(ahb8.HTRANS), 512'(2'b10));
        chk("ra_haddr0", 512'(ahb8.HADDR), 512'(BASE));
        tick();
        for (int k = 0; k < 8; k++) begin
            ahb8.HRDATA = 64'h300 + 64'(k);
            #2;
            chk("ra_re_beat", 512'(beatCount), 512'(k));
            chk("ra_re_ack", 512'(ack), 512'(k == 7));
            tick();
        end
        rw = 2'b00;
        tick();

        // 4-beat line: INCR4, ack on the fourth data beat
        chk("hburst4", 512'(ahb4.HBURST), 512'(3'b011));
        rw4 = 2'b10; adr4 = BASE; ahb4.HREADY = 1'b1;
        #2;
        chk("l4_nonseq", 512'(ahb4.HTRANS), 512'(2'b10));
        chk("l4_haddr0", 512'(ahb4.HADDR), 512'(BASE));
        tick();
        expFb4 = '0;
        for (int k = 0; k < 4; k++) begin
            ahb4.HRDATA = 64'hF00 + 64'(k);
            expFb4[k*64 +: 64] = 64'hF00 + 64'(k);
            #2;
            chk("l4_beat", 512'(beatCount4), 512'(k));
            chk("l4_ack", 512'(ack4), 512'(k == 3));
            chk("l4_htrans", 512'(ahb4.HTRANS), 512'((k < 3) ? 2'b11 : 2'b00));
            if (k < 3) chk("l4_haddr", 512'(ahb4.HADDR), 512'(BASE + 34'(8 * (k + 1))));
            tick();
        end
        rw4 = 2'b00;
        #2;
        chk("l4_done_state", 512'(dbgState4), 512'(S_DONE));
        chk("l4_fetchbuf", 512'(fetchBuf4), 512'(expFb4));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
